// File: rtl/reg_file_pair_sequencer.sv
// reg_file_pair_sequencer
// Request/response engine between the control unit and the dual-port (Rd/Rr)
// general register file. It handles single-register reads and writes, 16-bit
// register-pair reads, and an atomic pair read-modify-write with a signed delta.
// Optional build macro: RF_SPLIT_PAIR_WRITE_EN. When it is defined, the pair
// write goes through the rd port in two cycles (low byte, then high byte), so
// the Rr port can be read-only.
module reg_file_pair_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int R_ADDR_WIDTH = 5,
    parameter int DELTA_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [R_ADDR_WIDTH-1:0]       req_addr_a,
    input  logic [R_ADDR_WIDTH-1:0]       req_addr_b,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    input  logic signed [DELTA_WIDTH-1:0] req_delta,
    input  logic                          req_pre,
    output logic                          resp_valid,
    output logic [2*DATA_WIDTH-1:0]       resp_data,
    output logic [R_ADDR_WIDTH-1:0]       rd_addr,
    output logic [R_ADDR_WIDTH-1:0]       rr_addr,
    output logic                          rd_cs,
    output logic                          rr_cs,
    output logic                          rd_we,
    output logic                          rr_we,
    output logic                          rd_oe,
    output logic                          rr_oe,
    output logic [DATA_WIDTH-1:0]         rd_wdata,
    output logic [DATA_WIDTH-1:0]         rr_wdata,
    input  logic [DATA_WIDTH-1:0]         rd_rdata,
    input  logic [DATA_WIDTH-1:0]         rr_rdata
);

    localparam int PAIR_WIDTH = 2 * DATA_WIDTH;

    localparam logic [1:0] OP_READ2       = 2'b00;
    localparam logic [1:0] OP_WRITE1      = 2'b01;
    localparam logic [1:0] OP_READ_PAIR   = 2'b10;
    localparam logic [1:0] OP_UPDATE_PAIR = 2'b11;

    // S_WRITE_HI is only entered when the pair write is split across two cycles.
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_WRITE_HI,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // Request fields captured on the accept edge.
    logic [1:0]                    op_q;
    logic [R_ADDR_WIDTH-1:0]       addr_a_q;
    logic [R_ADDR_WIDTH-1:0]       addr_b_q;
    logic [DATA_WIDTH-1:0]         wdata_q;
    logic signed [DELTA_WIDTH-1:0] delta_q;
    logic                          pre_q;

    // Updated pair value and the response word.
    logic [PAIR_WIDTH-1:0]         upd_q;
    logic [PAIR_WIDTH-1:0]         resp_q;

    logic                          accept;
    logic                          is_pair;
    logic [R_ADDR_WIDTH-1:0]       pair_lo;
    logic [R_ADDR_WIDTH-1:0]       pair_hi;
    logic [PAIR_WIDTH-1:0]         rdata_pair;
    logic [PAIR_WIDTH-1:0]         rdata_upd;

    // Adds a sign-extended delta to the pair. The result wraps modulo 2^PAIR_WIDTH.
    function automatic logic [PAIR_WIDTH-1:0] pair_add(
        input logic [PAIR_WIDTH-1:0]         base,
        input logic signed [DELTA_WIDTH-1:0] delta
    );
        logic signed [PAIR_WIDTH-1:0] delta_ext;
        delta_ext = {{(PAIR_WIDTH-DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta};
        return base + delta_ext;
    endfunction

    assign req_ready  = reset & (state == S_IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = reset & (state == S_RESP);
    assign resp_data  = resp_q;

    // Pair ops ignore bit 0 of the base address: the low byte is at the even
    // address and the high byte is at the odd address.
    assign is_pair    = op_q[1];
    assign pair_lo    = {addr_a_q[R_ADDR_WIDTH-1:1], 1'b0};
    assign pair_hi    = {addr_a_q[R_ADDR_WIDTH-1:1], 1'b1};
    assign rdata_pair = {rr_rdata, rd_rdata};
    assign rdata_upd  = pair_add(rdata_pair, delta_q);

    // State register, request capture, and read-data latching in CAPT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wdata_q  <= '0;
            delta_q  <= '0;
            pre_q    <= 1'b0;
            upd_q    <= '0;
            resp_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= req_op;
                addr_a_q <= req_addr_a;
                addr_b_q <= req_addr_b;
                wdata_q  <= req_wdata;
                delta_q  <= req_delta;
                pre_q    <= req_pre;
            end
            if (state == S_CAPT) begin
                upd_q  <= rdata_upd;
                resp_q <= (op_q == OP_UPDATE_PAIR && pre_q) ? rdata_upd : rdata_pair;
            end
        end
    end

    // Next state and register-file strobes. While reset is low, all strobes
    // are held at 0 so an aborted operation issues nothing.
    always_comb begin
        state_nxt = state;
        rd_addr   = '0;
        rr_addr   = '0;
        rd_cs     = 1'b0;
        rr_cs     = 1'b0;
        rd_we     = 1'b0;
        rr_we     = 1'b0;
        rd_oe     = 1'b0;
        rr_oe     = 1'b0;
        rd_wdata  = '0;
        rr_wdata  = '0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (req_op == OP_WRITE1) ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                rd_cs     = 1'b1;
                rr_cs     = 1'b1;
                rd_oe     = 1'b1;
                rr_oe     = 1'b1;
                rd_addr   = is_pair ? pair_lo : addr_a_q;
                rr_addr   = is_pair ? pair_hi : addr_b_q;
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                state_nxt = (op_q == OP_UPDATE_PAIR) ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                rd_cs = 1'b1;
                rd_we = 1'b1;
                if (op_q == OP_WRITE1) begin
                    rd_addr   = addr_a_q;
                    rd_wdata  = wdata_q;
                    state_nxt = S_IDLE;
                end else begin
                    rd_addr  = pair_lo;
                    rd_wdata = upd_q[DATA_WIDTH-1:0];
`ifdef RF_SPLIT_PAIR_WRITE_EN
                    state_nxt = S_WRITE_HI;
`else
                    rr_cs     = 1'b1;
                    rr_we     = 1'b1;
                    rr_addr   = pair_hi;
                    rr_wdata  = upd_q[PAIR_WIDTH-1:DATA_WIDTH];
                    state_nxt = S_RESP;
`endif
                end
            end
            S_WRITE_HI: begin
                rd_cs     = 1'b1;
                rd_we     = 1'b1;
                rd_addr   = pair_hi;
                rd_wdata  = upd_q[PAIR_WIDTH-1:DATA_WIDTH];
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (!reset) begin
            state_nxt = S_IDLE;
            rd_addr   = '0;
            rr_addr   = '0;
            rd_cs     = 1'b0;
            rr_cs     = 1'b0;
            rd_we     = 1'b0;
            rr_we     = 1'b0;
            rd_oe     = 1'b0;
            rr_oe     = 1'b0;
            rd_wdata  = '0;
            rr_wdata  = '0;
        end
    end

endmodule

// File: doc/reg_file_pair_sequencer.md
Name: reg_file_pair_sequencer

Overview:
Multi-cycle sequencer that sits between the control unit and the dual-port (Rd/Rr) general register file. It replaces purely combinational per-state port decoding with a request/response engine. It serves single-register reads and writes, 16-bit register-pair reads (X/Y/Z-style pointers), and atomic pair read-modify-write with a signed delta, as used for post-increment, pre-decrement and ADIW/SBIW.

Parameters:
DATA_WIDTH, 8, register width; pair width is 2*DATA_WIDTH
R_ADDR_WIDTH, 5, register address width (32 registers)
DELTA_WIDTH, 6, width of signed pair delta, sign-extended to 2*DATA_WIDTH

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted on edge where req_valid&req_ready
req_op  in  2  00 READ2, 01 WRITE1, 10 READ_PAIR, 11 UPDATE_PAIR
req_addr_a  in  R_ADDR_WIDTH  Rd address / pair base (bit0 ignored for pair ops)
req_addr_b  in  R_ADDR_WIDTH  Rr address (READ2 only)
req_wdata  in  DATA_WIDTH  WRITE1 data
req_delta  in  DELTA_WIDTH  signed delta for UPDATE_PAIR
req_pre  in  1  UPDATE_PAIR: 1 returns updated value, 0 returns original
resp_valid  out  1  one-cycle pulse, resp_data valid
resp_data  out  2*DATA_WIDTH  READ2: {Rr,Rd}; pair ops: {high,low}
rd_addr, rr_addr  out  R_ADDR_WIDTH  register file port addresses
rd_cs, rr_cs, rd_we, rr_we, rd_oe, rr_oe  out  1 each  register file strobes
rd_wdata, rr_wdata  out  DATA_WIDTH  register file write data
rd_rdata, rr_rdata  in  DATA_WIDTH  register file read data, valid the cycle after cs&oe

Behaviour:
- Reset (reset==0 at an edge): state IDLE; resp_valid=0; resp_data=0; internal latches cleared. While reset==0, all cs/we/oe are forced to 0 combinationally and req_ready=0.
- Idle outputs: cs/we/oe=0; addresses and wdata=0. No X is driven.
- req_ready=1 only in IDLE. A request is captured (op, addresses, data, delta, pre) on the accept edge. Inputs are ignored otherwise.
- States: IDLE, READ, CAPT, WRITE, RESP.
- READ2: IDLE->READ (rd/rr cs=oe=1, addr=a/b) ->CAPT (latch rdata) ->RESP (resp_valid=1) ->IDLE. resp_valid is high 3 cycles after the accept edge.
- WRITE1: IDLE->WRITE (rd_cs=rd_we=1, rd_addr=a, rd_wdata=wdata) ->IDLE. Commits at the WRITE edge. No response.
- READ_PAIR: like READ2 with rd_addr={a[..1],0} and rr_addr={a[..1],1}. resp_data={rr,rd}.
- UPDATE_PAIR: READ->CAPT (orig={rr,rd}; upd=orig+sext(delta), modulo 2^(2*DATA_WIDTH)) ->WRITE (rd port writes upd low, rr port writes upd high, same cycle) ->RESP (resp_data = req_pre ? upd : orig) ->IDLE.
- oe and we are never both 1 on one port in any cycle.
- Reset asserted in any non-IDLE state: the operation is aborted, no strobe is issued in the reset cycle, no response is produced, and a partially completed pair write is not completed.
- resp has no backpressure; the consumer must sample during the pulse.

Optional Feature:
RF_SPLIT_PAIR_WRITE_EN: for register files whose Rr port is read-only. When defined, the UPDATE_PAIR WRITE stage becomes WRITE_LO (rd port writes low byte) then WRITE_HI (rd port writes high byte, addr base|1). rr_we is tied 0, and UPDATE latency grows by 1 cycle. Reset between the two cycles leaves the high byte unwritten. When undefined, both bytes are written in a single WRITE cycle via both ports.

Test Plan:
- Release reset, WRITE1 a=3 wdata=0x5A, then READ2 a=3 b=3 -> resp_data=0x5A5A, resp_valid exactly 3 cycles after accept, req_ready low while busy.
- Preload r26=0x34, r27=0x12, READ_PAIR a=27 (odd) -> resp_data=0x1234; rd_addr=26, rr_addr=27 in READ.
- r30=r31=0xFF, UPDATE_PAIR a=30 delta=+1 pre=0 -> resp_data=0xFFFF; r30=r31=0x00 afterwards (wrap).
- r28=r29=0x00, UPDATE_PAIR a=28 delta=-1 (6'h3F) pre=1 -> resp_data=0xFFFF; r28=r29=0xFF.
- Drive reset=0 during the WRITE state of an UPDATE_PAIR -> no cs/we that cycle, registers unchanged, no resp_valid; req_ready=1 on the first cycle after reset=1.
- With RF_SPLIT_PAIR_WRITE_EN, repeat the +1 wrap case -> two consecutive rd-port writes (addr 30 then 31), rr_we never 1, resp one cycle later than without the macro.
